// File: rtl/l2_l1d_responder.sv
// l2_l1d_responder
//
// L2-side responder for the L1 data-cache miss interface. It accepts one
// refill read and/or dirty-line writeback at a time from the L1 D-cache
// controller. Each request is serviced from a local line store after
// LATENCY wait cycles. Completion is signalled with a one-cycle
// ready_L2_L1 pulse.
//
// Parameters:
//   LATENCY     wait cycles from accept to completion (1..255)
//   DEPTH_LOG2  log2 of the number of 512-bit lines in the local store
//
// Ports:
//   clk               system clock, rising edge
//   nrst              synchronous active-low reset
//   read_L1_L2        refill request, level, held until ready_L2_L1
//   write_L1_L2       writeback request, level, held until ready_L2_L1
//   addr_L1_L2        line address {tag, index}; only the index selects a line
//   write_data_L1_L2  writeback line data
//   ready_L2_L1       one-cycle completion pulse
//   read_data_L2_L1   refill line data, held until the next read completion
//   busy              high whenever the FSM is not IDLE
//
// Optional build macro L2_L1D_RESP_STATS_EN adds the rd_count/wr_count
// outputs. These are 16-bit wrapping completion counters.

module l2_l1d_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         read_L1_L2,
  input  logic         write_L1_L2,
  input  logic [25:0]  addr_L1_L2,
  input  logic [511:0] write_data_L1_L2,
  output logic         ready_L2_L1,
  output logic [511:0] read_data_L2_L1,
  output logic         busy
`ifdef L2_L1D_RESP_STATS_EN
  ,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [1:0] COOL = 2'd3;

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  logic [1:0]   state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         rd_q, rd_d;
  logic         wr_q, wr_d;
  logic [25:0]  addr_q, addr_d;
  logic [511:0] wdata_q, wdata_d;
  logic         ready_q, ready_d;
  logic [511:0] rdata_q, rdata_d;

  logic [511:0] store [DEPTH];
  logic         store_we;
  logic         complete;
  logic [DEPTH_LOG2-1:0] idx;

  // Tag bits are latched with the request but never compared: lines alias
  // purely on index.
  logic unused_tag;
  assign unused_tag = ^addr_q[25:DEPTH_LOG2];

  assign idx = addr_q[DEPTH_LOG2-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    store_we = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_L1_L2 || write_L1_L2) begin
          rd_d    = read_L1_L2;
          wr_d    = write_L1_L2;
          addr_d  = addr_L1_L2;
          wdata_d = write_data_L1_L2;
          cnt_d   = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          complete = 1'b1;
          store_we = wr_q;
          // A combined request returns the post-write line, so forward the
          // write data instead of the old store contents.
          if (rd_q) begin
            rdata_d = wr_q ? wdata_q : store[idx];
          end
          ready_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: state_d = COOL;
      // Dead cycle that gives L1 time to drop its request after ready.
      COOL: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 26'd0;
      wdata_q <= 512'd0;
      ready_q <= 1'b0;
      rdata_q <= 512'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
    end
  end

  // The line store is not reset. Gating the write with nrst drops a
  // writeback that completes on the same edge reset is asserted.
  always_ff @(posedge clk) begin
    if (nrst && store_we) begin
      store[idx] <= wdata_q;
    end
  end

  assign ready_L2_L1     = ready_q;
  assign read_data_L2_L1 = rdata_q;
  assign busy            = (state_q != IDLE);

`ifdef L2_L1D_RESP_STATS_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (complete && rd_q) rd_cnt_d = rd_cnt_q + 16'd1;
    if (complete && wr_q) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  logic unused_complete;
  assign unused_complete = complete;
`endif

endmodule

// File: tb/tb_l2_l1d_responder.sv
// Scoreboard bench for l2_l1d_responder. Each issued transaction pushes its
// expected completion cycle and expected read_data_L2_L1 value into a queue.
// A monitor running on the falling edge pops the queue and compares whenever
// ready_L2_L1 is high.
module tb_l2_l1d_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         rd = 1'b0;
  logic         wr = 1'b0;
  logic [25:0]  addr = '0;
  logic [511:0] wdata = '0;
  logic         ready_L2_L1;
  logic [511:0] read_data_L2_L1;
  logic         busy;
`ifdef L2_L1D_RESP_STATS_EN
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;
`endif

  l2_l1d_responder #(.LATENCY(LAT), .DEPTH_LOG2(6)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .read_L1_L2       (rd),
    .write_L1_L2      (wr),
    .addr_L1_L2       (addr),
    .write_data_L1_L2 (wdata),
    .ready_L2_L1      (ready_L2_L1),
    .read_data_L2_L1  (read_data_L2_L1),
    .busy             (busy)
`ifdef L2_L1D_RESP_STATS_EN
    ,
    .rd_count         (rd_count),
    .wr_count         (wr_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int ready_seen = 0;
  logic [511:0] last_rd = '0;

  typedef struct {
    logic [511:0] data;
    int           at;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred, none required", name);
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (nrst && ready_L2_L1 === 1'b1) begin
      exp_t e;
      ready_seen++;
      if (sb.size() == 0) begin
        flag("spurious_ready");
      end else begin
        e = sb.pop_front();
        chk("ready_cycle", cyc, e.at);
        chk("read_data", read_data_L2_L1, e.data);
      end
    end
  end

  // Issue one request. If n > 1, the request stays high through COOL and
  // starts n back-to-back transactions. r_exp is the line a read returns.
  task automatic txn(input logic r, input logic w, input logic [25:0] a,
                     input logic [511:0] d, input logic [511:0] r_exp, input int n);
    int t0;
    int target;
    int guard;
    logic [511:0] e;
    guard = 0;
    @(posedge clk); #1;
    while (busy !== 1'b0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) flag("idle_timeout");
    rd = r; wr = w; addr = a; wdata = d;
    e = r ? r_exp : last_rd;
    if (r) last_rd = r_exp;
    target = ready_seen + n;
    @(posedge clk); #1;
    t0 = cyc;
    for (int k = 0; k < n; k++) sb.push_back('{e, t0 + k * (LAT + 3) + LAT});
    chk("busy_accept", busy, 1);
    guard = 0;
    while (ready_seen < target && guard < 50 * n) begin
      @(posedge clk);
      guard++;
    end
    if (guard >= 50 * n) flag("ready_timeout");
    #1;
    rd = 1'b0; wr = 1'b0;
    chk("busy_cool", busy, 1);
    @(posedge clk); #1;
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready_L2_L1, 0);
    chk("reset_busy", busy, 0);
    chk("reset_rdata", read_data_L2_L1, 0);
    nrst = 1'b1;

    txn(1'b0, 1'b1, 26'h0000005, {16{32'hDEADBEEF}}, '0, 1);
    txn(1'b1, 1'b0, 26'h0000005, '0, {16{32'hDEADBEEF}}, 1);
    txn(1'b1, 1'b1, 26'h0000011, 512'h1234, 512'h1234, 1);
    txn(1'b1, 1'b0, 26'h0000011, '0, 512'h1234, 1);
    txn(1'b0, 1'b1, 26'h0000043, 512'hA, '0, 1);
    txn(1'b1, 1'b0, 26'h0000003, '0, 512'hA, 1);
    txn(1'b0, 1'b1, 26'h0000007, 512'h5, '0, 1);

    // Reset in the second BUSY cycle of a write to line 7.
    @(posedge clk); #1;
    wr = 1'b1; addr = 26'h0000007; wdata = 512'h99;
    @(posedge clk); #1;
    chk("abort_busy_before", busy, 1);
    @(posedge clk); #1;
    nrst = 1'b0;
    wr = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", ready_L2_L1, 0);
    chk("abort_rdata", read_data_L2_L1, 0);
`ifdef L2_L1D_RESP_STATS_EN
    chk("reset_rd_count", rd_count, 0);
    chk("reset_wr_count", wr_count, 0);
`endif
    nrst = 1'b1;
    last_rd = '0;
    repeat (10) @(posedge clk);

    txn(1'b1, 1'b0, 26'h0000007, '0, 512'h5, 1);
    txn(1'b1, 1'b0, 26'h0000005, '0, {16{32'hDEADBEEF}}, 2);
    txn(1'b0, 1'b1, 26'h0000020, 512'h77, '0, 1);
    txn(1'b0, 1'b1, 26'h0000021, 512'h88, '0, 1);
    txn(1'b1, 1'b1, 26'h0000022, 512'h66, 512'h66, 1);
`ifdef L2_L1D_RESP_STATS_EN
    chk("rd_count", rd_count, 4);
    chk("wr_count", wr_count, 3);
`endif

    repeat (5) @(posedge clk);
    chk("outstanding", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/l2_l1d_responder.md
Name: l2_l1d_responder

Overview:
- L2-side responder for the L1 data-cache miss interface.
- Accepts line refill reads (read_L1_L2) and dirty-line writebacks (write_L1_L2) from the L1 D-cache controller.
- Services each request from a local line store after a fixed latency and returns a one-cycle ready_L2_L1 pulse. On reads it also returns a 512-bit line on read_data_L2_L1.
- Sits between the L1 D-cache top and the L2/memory model. It serves as the L2 stub in integration and as the front end of the real L2.

Parameters:
- LATENCY, 4: wait cycles from accept to completion. Legal range 1..255.
- DEPTH_LOG2, 6: log2 of the number of 512-bit lines in the local store.

Ports:
- clk  in  1  system clock, rising edge
- nrst  in  1  reset, synchronous, active-low
- read_L1_L2  in  1  refill request, level, held by L1 until ready_L2_L1
- write_L1_L2  in  1  writeback request, level, held by L1 until ready_L2_L1
- addr_L1_L2  in  26  line address, {tag[19:0], index[5:0]}
- write_data_L1_L2  in  512  writeback line data
- ready_L2_L1  out  1  one-cycle completion pulse
- read_data_L2_L1  out  512  refill line data
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset (nrst low at a rising edge):
  - state = IDLE, counter = 0, ready_L2_L1 = 0, read_data_L2_L1 = 0, busy = 0, latched request cleared.
  - Line store contents are not reset.
- States: IDLE, BUSY, RESP, COOL.
- IDLE:
  - If read_L1_L2 or write_L1_L2 is high, latch rd, wr, addr and write data.
  - Load counter with LATENCY-1 and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Request inputs are ignored; the latched copies are used.
  - If counter != 0, decrement the counter.
  - If counter == 0, complete at this edge:
    - If wr, store[addr[DEPTH_LOG2-1:0]] <= latched write data.
    - If rd, read_data_L2_L1 <= line at addr[DEPTH_LOG2-1:0], with write data forwarded when wr is also set (post-write value).
    - Go to RESP.
- RESP: ready_L2_L1 = 1 for exactly this cycle, then go to COOL.
- COOL: one dead cycle in which requests are ignored, so L1 has time to drop its request. Then go to IDLE.
- Latency: ready_L2_L1 is high exactly LATENCY+1 cycles after the first cycle the request is sampled high in IDLE.
- read_data_L2_L1:
  - Holds its value until the next read completion.
  - Write-only completions leave it unchanged.
- Simultaneous read_L1_L2 and write_L1_L2 in IDLE:
  - Handled as one transaction with a single ready pulse.
  - The write is committed, and the read returns the post-write line when the index matches.
- Index mapping: only addr[DEPTH_LOG2-1:0] selects the line. Upper address bits are aliased, with no tag check.
- Reset mid-transaction: abort immediately.
  - No ready pulse is issued.
  - A pending write is not committed.
  - read_data_L2_L1 is cleared to 0.
- Requests still high in IDLE after COOL start a new transaction. This covers the back-to-back case.
- busy = (state != IDLE).

Optional Feature:
- Macro: L2_L1D_RESP_STATS_EN.
- When defined, the block adds two output ports:
  - rd_count, 16 bits: increments at each completion with rd set.
  - wr_count, 16 bits: increments at each completion with wr set.
  - Both counters reset to 0, wrap from 0xFFFF to 0, and both increment on a combined transaction.
- When not defined, neither the ports nor the counters exist, and behaviour is otherwise identical.

Test Plan:
- LATENCY=4: write_L1_L2=1, addr=0x0000005, data={16{32'hDEADBEEF}} sampled at cycle 0 -> ready_L2_L1 high only in cycle 5; busy high in cycles 1-6; then read of addr 0x0000005 -> read_data_L2_L1={16{32'hDEADBEEF}} with ready_L2_L1 5 cycles after the request.
- Read and write both high, addr=0x0000011, data=512'h1234 -> single ready_L2_L1 pulse; read_data_L2_L1=512'h1234; a later read of 0x0000011 also returns 512'h1234.
- Aliasing, DEPTH_LOG2=6: write addr 0x0000043 with 512'hA, then read addr 0x0000003 -> returns 512'hA.
- Reset mid-transaction: nrst driven low in BUSY cycle 2 of a write to 0x0000007 (prior content 512'h5) -> no ready pulse, busy=0 the cycle after the reset edge; a later read of 0x0000007 returns 512'h5.
- Request held high through RESP, then dropped the cycle after ready -> exactly one ready pulse; request held high through COOL -> second transaction whose ready pulse arrives LATENCY+1 cycles after IDLE.
- L2_L1D_RESP_STATS_EN defined: 3 reads, 2 writes and 1 combined transaction -> rd_count=4, wr_count=3; after nrst, both counters read 0.
